// File: rtl/mode_event_router_pkg.sv
// Shared types for the panel button router: mode codes, event codes, FSM states.
package mode_event_router_pkg;

    localparam int unsigned MODE_W    = 2;
    localparam int unsigned NUM_MODES = 4;

    typedef enum logic [MODE_W-1:0] {
        MODE_TIME  = 2'b00,
        MODE_DATE  = 2'b01,
        MODE_SW    = 2'b10,
        MODE_ALARM = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        EVT_B0S = 2'b00,
        EVT_B0L = 2'b01,
        EVT_B1S = 2'b10,
        EVT_B1L = 2'b11
    } evt_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SWITCH  = 2'b01,
        ST_SETTING = 2'b10
    } state_e;

    typedef struct packed {
        logic valid;
        evt_e code;
    } evt_t;

    function automatic logic [NUM_MODES-1:0] mode_onehot(input mode_e m);
        return NUM_MODES'(1) << m;
    endfunction

endpackage

// File: rtl/mode_event_router_btn_evt_enc.sv
// Fixed-priority button event encoder: B0SHORT > B0LONG > B1SHORT > B1LONG.
module btn_evt_enc
    import mode_event_router_pkg::*;
(
    input  logic b0short_i,
    input  logic b0long_i,
    input  logic b1short_i,
    input  logic b1long_i,
    output evt_t evt_c_o
);

    always_comb begin
        evt_c_o = '0;
        if (b0short_i) begin
            evt_c_o = '{valid: 1'b1, code: EVT_B0S};
        end else if (b0long_i) begin
            evt_c_o = '{valid: 1'b1, code: EVT_B0L};
        end else if (b1short_i) begin
            evt_c_o = '{valid: 1'b1, code: EVT_B1S};
        end else if (b1long_i) begin
            evt_c_o = '{valid: 1'b1, code: EVT_B1L};
        end
    end

endmodule

// File: rtl/mode_event_router.sv
// Button-event router and display-mode sequencer for the clock/date panel.
// Optional setting-session timeout is built when MODE_TIMEOUT_EN is defined.
module mode_event_router
    import mode_event_router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 30
) (
    input  logic                 OneClk,
    input  logic                 rst,
    input  logic                 b0short_i,
    input  logic                 b0long_i,
    input  logic                 b1short_i,
    input  logic                 b1long_i,
    input  logic [NUM_MODES-1:0] setting_in_i,
    output logic [MODE_W-1:0]    mode_o,
    output logic                 evt_valid_o,
    output logic [1:0]           evt_code_o,
    output logic [NUM_MODES-1:0] evt_grant_o,
    output logic                 mode_change_o,
    output logic [NUM_MODES-1:0] force_exit_o
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("mode_event_router: TIMEOUT must be at least 2");
    end

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    evt_t                  hold_q, hold_d;
    logic                  evt_valid_q, evt_valid_d;
    evt_e                  evt_code_q, evt_code_d;
    logic [NUM_MODES-1:0]  evt_grant_q, evt_grant_d;
    logic                  mode_change_q, mode_change_d;
    evt_t                  fresh_c;
    evt_t                  src_c;
    logic                  cur_set_c;

    btn_evt_enc u_enc (
        .b0short_i (b0short_i),
        .b0long_i  (b0long_i),
        .b1short_i (b1short_i),
        .b1long_i  (b1long_i),
        .evt_c_o   (fresh_c)
    );

    assign cur_set_c = setting_in_i[mode_q];

    // Next-state: a buffered event from the switch cycle replaces any fresh one.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        hold_d        = hold_q;
        evt_valid_d   = 1'b0;
        evt_code_d    = evt_code_q;
        evt_grant_d   = '0;
        mode_change_d = 1'b0;
        src_c         = fresh_c;

        unique case (state_q)
            ST_IDLE: begin
                if (hold_q.valid) begin
                    src_c = hold_q;
                end
                hold_d = '0;
                if (src_c.valid && (src_c.code == EVT_B0S)) begin
                    mode_d        = mode_e'(mode_q + MODE_W'(1));
                    mode_change_d = 1'b1;
                    state_d       = ST_SWITCH;
                end else begin
                    if (src_c.valid) begin
                        evt_valid_d = 1'b1;
                        evt_code_d  = src_c.code;
                        evt_grant_d = mode_onehot(mode_q);
                    end
                    if (cur_set_c) begin
                        state_d = ST_SETTING;
                    end
                end
            end
            ST_SWITCH: begin
                hold_d  = fresh_c;
                state_d = ST_IDLE;
            end
            ST_SETTING: begin
                if (fresh_c.valid) begin
                    evt_valid_d = 1'b1;
                    evt_code_d  = fresh_c.code;
                    evt_grant_d = mode_onehot(mode_q);
                end
                if (!cur_set_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge OneClk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_TIME;
            hold_q        <= '0;
            evt_valid_q   <= 1'b0;
            evt_code_q    <= EVT_B0S;
            evt_grant_q   <= '0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            hold_q        <= hold_d;
            evt_valid_q   <= evt_valid_d;
            evt_code_q    <= evt_code_d;
            evt_grant_q   <= evt_grant_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign mode_o        = mode_q;
    assign evt_valid_o   = evt_valid_q;
    assign evt_code_o    = evt_code_q;
    assign evt_grant_o   = evt_grant_q;
    assign mode_change_o = mode_change_q;

`ifdef MODE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_MODES-1:0] force_q, force_d;

    // Counter only advances on quiet SETTING cycles; everything else parks it at 0.
    always_comb begin
        cnt_d   = '0;
        force_d = '0;
        if ((state_q == ST_SETTING) && cur_set_c && !evt_valid_d) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                force_d = mode_onehot(mode_q);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge OneClk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            force_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            force_q <= force_d;
        end
    end

    assign force_exit_o = force_q;
`else
    assign force_exit_o = '0;
`endif

endmodule
